// File: rtl/mult_issue_queue.sv
// Multiply reservation station: collapsing age-ordered queue that snoops the CDB
// for pending operands and issues the oldest ready op when the arbiter grants a slot.

module mult_iq_slot #(
  parameter int TAG_W = 6,
  parameter int EW    = 1 + 3 + TAG_W + 2 * (33 + TAG_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_shift,
  input  logic             i_wr,
  input  logic [EW-1:0]    i_up,
  input  logic [EW-1:0]    i_new,
  input  logic             i_cdb_valid,
  input  logic [TAG_W-1:0] i_cdb_tag,
  input  logic [31:0]      i_cdb_data,
  output logic [EW-1:0]    o_ent
);
  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             rdy;
  } opnd_t;

  typedef struct packed {
    logic             vld;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rd_tag;
    opnd_t            op1;
    opnd_t            op2;
  } ent_t;

  ent_t r_ent, w_src, w_nxt, w_up, w_new;

  assign w_up  = i_up;
  assign w_new = i_new;

  // A write lands on the slot freed by the shift, so it takes priority over the neighbour.
  always_comb begin
    w_src = r_ent;
    if (i_wr)
      w_src = w_new;
    else if (i_shift)
      w_src = w_up;
  end

  // Wakeup is applied after the shift/write select, so captures follow the entry
  // into its new slot and also cover the dispatch bypass.
  always_comb begin
    w_nxt = w_src;
    if (w_src.vld && i_cdb_valid) begin
      if (!w_src.op1.rdy && w_src.op1.tag == i_cdb_tag) begin
        w_nxt.op1.data = i_cdb_data;
        w_nxt.op1.rdy  = 1'b1;
      end
      if (!w_src.op2.rdy && w_src.op2.tag == i_cdb_tag) begin
        w_nxt.op2.data = i_cdb_data;
        w_nxt.op2.rdy  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_ent <= '0;
    else if (i_flush)
      r_ent <= '0;
    else
      r_ent <= w_nxt;
  end

  assign o_ent = r_ent;
endmodule

module mult_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             dispatch_en,
  input  logic [2:0]       dispatch_funct3,
  input  logic [TAG_W-1:0] dispatch_rd_tag,
  input  logic [31:0]      dispatch_rs1_data,
  input  logic [TAG_W-1:0] dispatch_rs1_tag,
  input  logic             dispatch_rs1_valid,
  input  logic [31:0]      dispatch_rs2_data,
  input  logic [TAG_W-1:0] dispatch_rs2_tag,
  input  logic             dispatch_rs2_valid,
  output logic             queue_full,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  input  logic             issue_grant,
  output logic             issue_en,
  output logic [31:0]      issue_op1,
  output logic [31:0]      issue_op2,
  output logic [2:0]       issue_funct3,
  output logic [TAG_W-1:0] issue_tag,
  output logic             issue_tag_valid
);
  localparam int EW = 1 + 3 + TAG_W + 2 * (33 + TAG_W);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             rdy;
  } opnd_t;

  typedef struct packed {
    logic             vld;
    logic [2:0]       funct3;
    logic [TAG_W-1:0] rd_tag;
    opnd_t            op1;
    opnd_t            op2;
  } ent_t;

  logic [DEPTH-1:0][EW-1:0] w_ent_bus;
  logic [DEPTH-1:0]         w_rdy;
  logic [CW-1:0]            r_cnt;
  logic [CW-1:0]            w_wr_idx;
  logic [IW-1:0]            w_sel;
  logic                     w_any, w_issue, w_acc, w_full;
  ent_t                     w_new, w_out;
  logic                     w_unused;

  assign w_full = (r_cnt == CW'(DEPTH));
  assign queue_full = w_full;

  always_comb begin
    w_new            = '0;
    w_new.vld        = 1'b1;
    w_new.funct3     = dispatch_funct3;
    w_new.rd_tag     = dispatch_rd_tag;
    w_new.op1.data   = dispatch_rs1_data;
    w_new.op1.tag    = dispatch_rs1_tag;
    w_new.op1.rdy    = dispatch_rs1_valid;
    w_new.op2.data   = dispatch_rs2_data;
    w_new.op2.tag    = dispatch_rs2_tag;
    w_new.op2.rdy    = dispatch_rs2_valid;
  end

  // Lowest index wins: index 0 is always the oldest entry.
  always_comb begin
    w_sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--)
      if (w_rdy[k]) w_sel = IW'(k);
  end

  assign w_any    = |w_rdy;
  assign w_issue  = issue_grant & w_any & ~flush;
  assign w_acc    = dispatch_en & ~w_full & ~flush;
  assign w_wr_idx = r_cnt - CW'(w_issue);

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_slot
      ent_t             w_e;
      logic [EW-1:0]    w_up;
      logic             w_shift, w_wr;

      assign w_e      = w_ent_bus[i];
      assign w_rdy[i] = w_e.vld & w_e.op1.rdy & w_e.op2.rdy;
      assign w_shift  = w_issue && (w_sel <= IW'(i));
      assign w_wr     = w_acc && (w_wr_idx == CW'(i));

      if (i < DEPTH - 1) begin : g_up
        assign w_up = w_ent_bus[i+1];
      end else begin : g_top
        assign w_up = '0;
      end

      mult_iq_slot #(.TAG_W(TAG_W), .EW(EW)) u_slot (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_shift     (w_shift),
        .i_wr        (w_wr),
        .i_up        (w_up),
        .i_new       (w_new),
        .i_cdb_valid (cdb_valid),
        .i_cdb_tag   (cdb_tag),
        .i_cdb_data  (cdb_data),
        .o_ent       (w_ent_bus[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (flush)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + CW'(w_acc) - CW'(w_issue);
  end

  assign w_out           = w_ent_bus[w_sel];
  assign issue_en        = w_issue;
  assign issue_tag_valid = w_issue;
  assign issue_op1       = w_issue ? w_out.op1.data : '0;
  assign issue_op2       = w_issue ? w_out.op2.data : '0;
  assign issue_funct3    = w_issue ? w_out.funct3   : '0;
  assign issue_tag       = w_issue ? w_out.rd_tag   : '0;

  assign w_unused = ^{w_out.vld, w_out.op1.tag, w_out.op1.rdy, w_out.op2.tag, w_out.op2.rdy};
endmodule

// File: doc/mult_issue_queue.md
Name: mult_issue_queue

Overview:
- Reservation station for the multiply functional unit.
- Accepts dispatched multiply ops whose operands may still be pending, and snoops the CDB for missing operands.
- Issues the oldest ready entry to the multiply pipeline, one op per cycle.
- Issue is gated by a CDB-slot grant from the arbiter. The multiply pipeline has no backpressure, so the grant is the only flow control.

Parameters:
DEPTH, 4, number of queue entries (2..8)
TAG_W, 6, ROB/rename tag width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of all entries (mispredict)
dispatch_en  in  1  write new entry this cycle
dispatch_funct3  in  3  multiply variant
dispatch_rd_tag  in  TAG_W  destination tag
dispatch_rs1_data  in  32  operand 1 value (meaningful if valid)
dispatch_rs1_tag  in  TAG_W  producer tag of operand 1
dispatch_rs1_valid  in  1  operand 1 value present
dispatch_rs2_data  in  32  operand 2 value
dispatch_rs2_tag  in  TAG_W  producer tag of operand 2
dispatch_rs2_valid  in  1  operand 2 value present
queue_full  out  1  count == DEPTH
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB broadcast tag
cdb_data  in  32  CDB broadcast value
issue_grant  in  1  arbiter permits issue this cycle
issue_en  out  1  to multiply unit queue_en
issue_op1  out  32  operand 1
issue_op2  out  32  operand 2
issue_funct3  out  3  funct3
issue_tag  out  TAG_W  destination tag
issue_tag_valid  out  1  tag valid (equals issue_en)

Behaviour:
- Reset (rst low, async): all entries invalid, count=0, queue_full=0. All issue_* outputs are 0 while in reset.
- Storage is a collapsing age-ordered array. Index 0 is the oldest entry. Each entry holds valid, funct3, rd_tag, and per operand {data, tag, rdy}.
- Ready rule: an entry is ready when valid, op1 rdy and op2 rdy, all taken from registered state.
- An operand woken by the CDB in cycle N makes its entry eligible in N+1.
- Issue is combinational from registered state. issue_en=1 iff issue_grant=1 and at least one entry is ready.
  - The lowest-index ready entry is selected.
  - op1, op2, funct3 and rd_tag drive the issue_* outputs; issue_tag_valid=1.
  - The selected entry is removed at the clock edge. Entries above it shift down by one.
- When issue_en=0, all issue_* outputs are 0.
- CDB wakeup: every valid entry's non-rdy operand with tag==cdb_tag and cdb_valid=1 captures cdb_data and sets rdy at the edge. This applies to shifting entries as well: the capture lands in their new slot.
- Dispatch: if dispatch_en=1 and queue_full=0, the new entry is written at index count, or at count-1 if an issue occurs the same cycle.
- Dispatch bypass: a dispatched operand with valid=0 whose tag matches a valid CDB broadcast in the same cycle is stored with cdb_data and rdy=1.
- dispatch_en while queue_full=1: ignored, no state change. This holds even if an issue occurs that cycle.
- Simultaneous dispatch, issue and CDB wakeup are all honoured in one edge.
- count' = count + (dispatch accepted) − (issue_en).
- queue_full is combinational from registered count.
- flush=1: all entries are invalidated at the edge and count=0. Dispatch and CDB wakeup that cycle are discarded. issue_en is still forced to 0 that cycle.
- Reset asserted mid-operation: state is cleared immediately. No partial issue is held over.
- The block never issues more than one op per cycle and never reorders issue ahead of an older ready entry.

Test Plan:
1. Reset then dispatch {rs1=7 valid, rs2=6 valid, funct3=0, rd_tag=5} with issue_grant=1 -> next cycle issue_en=1, op1=7, op2=6, issue_tag=5; the following cycle count=0 and issue_en=0.
2. Dispatch an entry with rs2 pending on tag 9 -> no issue. Then cdb_valid=1, tag=9, data=3 in cycle N -> issue in N+1 with op2=3. Repeat with the CDB tag matching in the same cycle as dispatch -> bypass captured and issue in the next cycle.
3. Fill 4 entries with grant=0 -> queue_full=1. A further dispatch {rd_tag=12} is dropped. Raise grant -> tags issue in age order 1, 2, 3, 4, one per cycle.
4. Entries A (not ready), B (ready), C (ready) -> B issues first, then C. A issues one cycle after its CDB wakeup. The entries shift correctly throughout.
5. Queue at count=3 with an issue and a dispatch in the same cycle -> count stays 3, and the new entry sits at index 2 and is issued last.
6. flush with 3 valid entries and a simultaneous dispatch -> count=0 and no issue afterwards. Assert rst mid-stream -> all issue_* outputs go to 0 immediately (asynchronously).
